// File: rtl/ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle MIPS-subset control unit:
//   - FSM state encoding (IF/ID/EX/MEM/WB/HALT)
//   - opcode and R-type funct constants for the supported instructions
//   - encodings of every datapath mux select and the ALU operation
//   - bit positions of the one-hot instruction class vector
//   - a helper that maps an R-type funct to its ALU operation
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd7
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_SLT = 2'd2,
        ALU_XOR = 2'd3
    } alu_op_t;

    typedef enum logic [1:0] {
        SRCB_REGB = 2'd0,
        SRCB_FOUR = 2'd1,
        SRCB_SEXT = 2'd2,
        SRCB_ZEXT = 2'd3
    } alu_src_b_t;

    typedef enum logic [1:0] {
        DST_RT = 2'd0,
        DST_RD = 2'd1,
        DST_RA = 2'd2
    } reg_dst_t;

    typedef enum logic [1:0] {
        M2R_ALU = 2'd0,
        M2R_MDR = 2'd1,
        M2R_PC  = 2'd2
    } mem_to_reg_t;

    typedef enum logic [1:0] {
        PCS_ALU    = 2'd0,
        PCS_BRANCH = 2'd1,
        PCS_JUMP   = 2'd2,
        PCS_REGA   = 2'd3
    } pc_src_t;

    localparam int CLS_W       = 10;
    localparam int CLS_RTYPE   = 0;
    localparam int CLS_JR      = 1;
    localparam int CLS_IMM_ADD = 2;
    localparam int CLS_IMM_XOR = 3;
    localparam int CLS_J       = 4;
    localparam int CLS_JAL     = 5;
    localparam int CLS_BR      = 6;
    localparam int CLS_LW      = 7;
    localparam int CLS_SW      = 8;
    localparam int CLS_ILLEGAL = 9;

    // Only ADD/SUB/SLT reach EX as R-type ops, so anything that is not
    // SUB or SLT falls back to ADD.
    function automatic alu_op_t rtypeAluOp(input logic [5:0] fn);
        case (fn)
            FN_SUB:  return ALU_SUB;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/instr_decode.sv
// ---------------------------------------------------------------------------
// instr_decode
// Purely combinational instruction classifier. Turns the opcode and funct
// fields of the instruction register into a one-hot class vector that the
// control FSM steers on. Exactly one bit of o_class is set for any input;
// everything not recognised lands in the ILLEGAL class.
//
// Ports:
//   i_opcode  in  6       IR[31:26]
//   i_funct   in  6       IR[5:0], only meaningful for R-type
//   o_class   out CLS_W   one-hot class, bit positions from ctrl_pkg
// ---------------------------------------------------------------------------
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_funct,
    output logic [CLS_W-1:0] o_class
);

    // Classify the instruction. R-type opcodes are split further on funct,
    // and an unknown funct is just as illegal as an unknown opcode.
    always_comb begin
        o_class = '0;
        case (i_opcode)
            OP_RTYPE: begin
                case (i_funct)
                    FN_ADD, FN_SUB, FN_SLT: o_class[CLS_RTYPE]   = 1'b1;
                    FN_JR:                  o_class[CLS_JR]      = 1'b1;
                    default:                o_class[CLS_ILLEGAL] = 1'b1;
                endcase
            end
            OP_ADDI:         o_class[CLS_IMM_ADD] = 1'b1;
            OP_XORI:         o_class[CLS_IMM_XOR] = 1'b1;
            OP_J:            o_class[CLS_J]       = 1'b1;
            OP_JAL:          o_class[CLS_JAL]     = 1'b1;
            OP_BEQ, OP_BNE:  o_class[CLS_BR]      = 1'b1;
            OP_LW:           o_class[CLS_LW]      = 1'b1;
            OP_SW:           o_class[CLS_SW]      = 1'b1;
            default:         o_class[CLS_ILLEGAL] = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Control unit for the multicycle MIPS-subset CPU. Walks every instruction
// through IF/ID/EX/MEM/WB, issues all datapath enables and mux selects,
// stalls on the instruction and data memory ready handshakes, traps (or
// skips) undefined instructions and counts retired instructions.
//
// Parameters:
//   IMEM_WAIT        1: IF waits for imem_ready, 0: single-cycle fetch
//   DMEM_WAIT        1: MEM waits for dmem_ready, 0: single-cycle access
//   TRAP_ON_ILLEGAL  1: undefined instruction halts, 0: treated as NOP
//   CNT_W            width of the retired-instruction counter
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   opcode, funct         instruction fields from the IR
//   zero                  ALU zero flag (branch decision)
//   imem_ready            instruction memory data valid
//   dmem_ready            data memory access complete
//   pc_we, ir_we, reg_we  PC / IR / register file write enables
//   mem_re, mem_we        memory read / write enables
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_op                ALU operation
//   reg_dst, mem_to_reg   register file write address / data selects
//   pc_src                next-PC select
//   state                 current FSM state
//   illegal               sticky trap flag
//   retire                pulse on the final cycle of an instruction
//   instret               retired-instruction count
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter logic IMEM_WAIT       = 1'b1,
    parameter logic DMEM_WAIT       = 1'b1,
    parameter logic TRAP_ON_ILLEGAL = 1'b1,
    parameter int   CNT_W           = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             pc_we,
    output logic             ir_we,
    output logic             reg_we,
    output logic             mem_re,
    output logic             mem_we,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic [1:0]       pc_src,
    output logic [2:0]       state,
    output logic             illegal,
    output logic             retire,
    output logic [CNT_W-1:0] instret
);

    state_t           r_state;
    state_t           w_nextState;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instret;
    logic [CLS_W-1:0] w_class;
    logic             w_fetchOk;
    logic             w_memOk;
    logic             w_branchTaken;
    logic             w_retire;
    logic             w_trap;

    instr_decode u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_class  (w_class)
    );

    // With waiting disabled the handshakes are ignored and every fetch or
    // data access completes in the cycle it is issued.
    assign w_fetchOk = !IMEM_WAIT || imem_ready;
    assign w_memOk   = !DMEM_WAIT || dmem_ready;

    // BEQ and BNE share the BR class; the opcode picks the zero polarity.
    assign w_branchTaken = (opcode == OP_BNE) ? !zero : zero;

    // State register. Reset drops any in-flight instruction and restarts
    // fetching from IF on the first cycle after reset is released.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IF;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and every control output. Defaults park all enables low
    // and all selects at 0, so each state only has to mention what it
    // actually uses. Retire is flagged explicitly on transitions that end
    // an instruction, which keeps a stalled IF from looking like a retire.
    // Reset overrides everything at the end so no write can leak out while
    // it is held.
    always_comb begin
        w_nextState = r_state;
        pc_we       = 1'b0;
        ir_we       = 1'b0;
        reg_we      = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRCB_REGB;
        alu_op      = ALU_ADD;
        reg_dst     = DST_RT;
        mem_to_reg  = M2R_ALU;
        pc_src      = PCS_ALU;
        w_retire    = 1'b0;
        w_trap      = 1'b0;

        unique case (r_state)
            S_IF: begin
                alu_src_b = SRCB_FOUR;
                if (w_fetchOk) begin
                    mem_re      = 1'b1;
                    ir_we       = 1'b1;
                    pc_we       = 1'b1;
                    w_nextState = S_ID;
                end
            end

            S_ID: begin
                if (w_class[CLS_JR]) begin
                    pc_we       = 1'b1;
                    pc_src      = PCS_REGA;
                    w_retire    = 1'b1;
                    w_nextState = S_IF;
                end else if (w_class[CLS_J]) begin
                    pc_we       = 1'b1;
                    pc_src      = PCS_JUMP;
                    w_retire    = 1'b1;
                    w_nextState = S_IF;
                end else if (w_class[CLS_JAL]) begin
                    w_nextState = S_WB;
                end else if (w_class[CLS_ILLEGAL]) begin
                    if (TRAP_ON_ILLEGAL) begin
                        w_trap      = 1'b1;
                        w_nextState = S_HALT;
                    end else begin
                        w_retire    = 1'b1;
                        w_nextState = S_IF;
                    end
                end else begin
                    w_nextState = S_EX;
                end
            end

            S_EX: begin
                alu_src_a = 1'b1;
                if (w_class[CLS_RTYPE]) begin
                    alu_src_b   = SRCB_REGB;
                    alu_op      = rtypeAluOp(funct);
                    w_nextState = S_WB;
                end else if (w_class[CLS_IMM_ADD]) begin
                    alu_src_b   = SRCB_SEXT;
                    alu_op      = ALU_ADD;
                    w_nextState = S_WB;
                end else if (w_class[CLS_IMM_XOR]) begin
                    alu_src_b   = SRCB_ZEXT;
                    alu_op      = ALU_XOR;
                    w_nextState = S_WB;
                end else if (w_class[CLS_BR]) begin
                    alu_src_b   = SRCB_REGB;
                    alu_op      = ALU_SUB;
                    if (w_branchTaken) begin
                        pc_we  = 1'b1;
                        pc_src = PCS_BRANCH;
                    end
                    w_retire    = 1'b1;
                    w_nextState = S_IF;
                end else if (w_class[CLS_LW] || w_class[CLS_SW]) begin
                    alu_src_b   = SRCB_SEXT;
                    alu_op      = ALU_ADD;
                    w_nextState = S_MEM;
                end else begin
                    w_nextState = S_IF;
                end
            end

            S_MEM: begin
                if (w_class[CLS_LW]) begin
                    mem_re = 1'b1;
                end else begin
                    mem_we = 1'b1;
                end
                if (w_memOk) begin
                    if (w_class[CLS_LW]) begin
                        w_nextState = S_WB;
                    end else begin
                        w_retire    = 1'b1;
                        w_nextState = S_IF;
                    end
                end
            end

            S_WB: begin
                reg_we = 1'b1;
                if (w_class[CLS_JAL]) begin
                    reg_dst    = DST_RA;
                    mem_to_reg = M2R_PC;
                    pc_we      = 1'b1;
                    pc_src     = PCS_JUMP;
                end else if (w_class[CLS_LW]) begin
                    reg_dst    = DST_RT;
                    mem_to_reg = M2R_MDR;
                end else if (w_class[CLS_RTYPE]) begin
                    reg_dst    = DST_RD;
                end else begin
                    reg_dst    = DST_RT;
                end
                w_retire    = 1'b1;
                w_nextState = S_IF;
            end

            S_HALT: begin
                w_nextState = S_HALT;
            end

            default: begin
                w_nextState = S_IF;
            end
        endcase

        if (reset) begin
            pc_we      = 1'b0;
            ir_we      = 1'b0;
            reg_we     = 1'b0;
            mem_re     = 1'b0;
            mem_we     = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = SRCB_REGB;
            alu_op     = ALU_ADD;
            reg_dst    = DST_RT;
            mem_to_reg = M2R_ALU;
            pc_src     = PCS_ALU;
            w_retire   = 1'b0;
            w_trap     = 1'b0;
        end
    end

    // Sticky trap flag: set when an illegal instruction halts the core and
    // only cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal <= 1'b0;
        end else if (w_trap) begin
            r_illegal <= 1'b1;
        end
    end

    // Retired-instruction counter. It wraps naturally at 2^CNT_W, and reset
    // takes priority over a retire in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    assign state   = r_state;
    assign illegal = r_illegal;
    assign retire  = w_retire;
    assign instret = r_instret;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
// Table-driven bench for multicycle_ctrl. Each row holds the inputs for one
// clock cycle and the control outputs expected during that cycle. A second
// instance built with TRAP_ON_ILLEGAL=0 sees the same stimulus and is
// checked around the undefined-opcode instruction.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        imem_ready;
    logic        dmem_ready;

    logic        pc_we, ir_we, reg_we, mem_re, mem_we, alu_src_a;
    logic [1:0]  alu_src_b, alu_op, reg_dst, mem_to_reg, pc_src;
    logic [2:0]  state;
    logic        illegal, retire;
    logic [31:0] instret;

    logic        pcWeN, irWeN, regWeN, memReN, memWeN, aluSrcAN;
    logic [1:0]  aluSrcBN, aluOpN, regDstN, memToRegN, pcSrcN;
    logic [2:0]  stateN;
    logic        illegalN, retireN;
    logic [31:0] instretN;

    typedef struct packed {
        logic       rst;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       ir;
        logic       dr;
        logic [2:0] st;
        logic [4:0] en;
        logic       a;
        logic [1:0] b;
        logic [1:0] aop;
        logic [1:0] dst;
        logic [1:0] m2r;
        logic [1:0] psrc;
        logic       ret;
        logic       ill;
    } step_t;

    step_t       vecs[$];
    step_t       expQ[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] expInstret = '0;
    int          idxIllId = -1;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .pc_we      (pc_we),
        .ir_we      (ir_we),
        .reg_we     (reg_we),
        .mem_re     (mem_re),
        .mem_we     (mem_we),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .pc_src     (pc_src),
        .state      (state),
        .illegal    (illegal),
        .retire     (retire),
        .instret    (instret)
    );

    multicycle_ctrl #(.TRAP_ON_ILLEGAL(1'b0)) dutNoTrap (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .pc_we      (pcWeN),
        .ir_we      (irWeN),
        .reg_we     (regWeN),
        .mem_re     (memReN),
        .mem_we     (memWeN),
        .alu_src_a  (aluSrcAN),
        .alu_src_b  (aluSrcBN),
        .alu_op     (aluOpN),
        .reg_dst    (regDstN),
        .mem_to_reg (memToRegN),
        .pc_src     (pcSrcN),
        .state      (stateN),
        .illegal    (illegalN),
        .retire     (retireN),
        .instret    (instretN)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    function automatic void addRow(
        input logic rst, input logic [5:0] op, input logic [5:0] fn,
        input logic z, input logic ir, input logic dr,
        input logic [2:0] st, input logic [4:0] en, input logic a,
        input logic [1:0] b, input logic [1:0] aop, input logic [1:0] dst,
        input logic [1:0] m2r, input logic [1:0] psrc,
        input logic ret, input logic ill);
        vecs.push_back({rst, op, fn, z, ir, dr, st, en, a, b, aop, dst, m2r, psrc, ret, ill});
    endfunction

    function automatic void rowIF(input logic [5:0] op, input logic [5:0] fn, input logic z);
        addRow(1'b0, op, fn, z, 1'b1, 1'b1, 3'd0, 5'b11010, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    endfunction

    function automatic void rowID(input logic [5:0] op, input logic [5:0] fn, input logic z);
        addRow(1'b0, op, fn, z, 1'b1, 1'b1, 3'd1, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    endfunction

    // Enable field order: {pc_we, ir_we, reg_we, mem_re, mem_we}.
    function automatic void fillTable();
        addRow(1'b1, 6'h00, 6'h00, 1'b0, 1'b1, 1'b1, 3'd0, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);

        rowIF(6'h00, 6'h20, 1'b0);
        rowID(6'h00, 6'h20, 1'b0);
        addRow(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 1'b1, 3'd2, 5'b00000, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        addRow(1'b0, 6'h00, 6'h20, 1'b0, 1'b1, 1'b1, 3'd4, 5'b00100, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0);

        rowIF(6'h23, 6'h00, 1'b0);
        rowID(6'h23, 6'h00, 1'b0);
        addRow(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 1'b1, 3'd2, 5'b00000, 1'b1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            addRow(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 1'b0, 3'd3, 5'b00010, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        end
        addRow(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 1'b1, 3'd3, 5'b00010, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        addRow(1'b0, 6'h23, 6'h00, 1'b0, 1'b1, 1'b1, 3'd4, 5'b00100, 1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 1'b1, 1'b0);

        rowIF(6'h04, 6'h00, 1'b1);
        rowID(6'h04, 6'h00, 1'b1);
        addRow(1'b0, 6'h04, 6'h00, 1'b1, 1'b1, 1'b1, 3'd2, 5'b10000, 1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);

        rowIF(6'h05, 6'h00, 1'b1);
        rowID(6'h05, 6'h00, 1'b1);
        addRow(1'b0, 6'h05, 6'h00, 1'b1, 1'b1, 1'b1, 3'd2, 5'b00000, 1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);

        rowIF(6'h05, 6'h00, 1'b0);
        rowID(6'h05, 6'h00, 1'b0);
        addRow(1'b0, 6'h05, 6'h00, 1'b0, 1'b1, 1'b1, 3'd2, 5'b10000, 1'b1, 2'd0, 2'd1, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);

        rowIF(6'h03, 6'h00, 1'b0);
        rowID(6'h03, 6'h00, 1'b0);
        addRow(1'b0, 6'h03, 6'h00, 1'b0, 1'b1, 1'b1, 3'd4, 5'b10100, 1'b0, 2'd0, 2'd0, 2'd2, 2'd2, 2'd2, 1'b1, 1'b0);

        addRow(1'b0, 6'h02, 6'h00, 1'b0, 1'b0, 1'b1, 3'd0, 5'b00000, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        rowIF(6'h02, 6'h00, 1'b0);
        addRow(1'b0, 6'h02, 6'h00, 1'b0, 1'b1, 1'b1, 3'd1, 5'b10000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0);

        rowIF(6'h00, 6'h08, 1'b0);
        addRow(1'b0, 6'h00, 6'h08, 1'b0, 1'b1, 1'b1, 3'd1, 5'b10000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 1'b1, 1'b0);

        rowIF(6'h2B, 6'h00, 1'b0);
        rowID(6'h2B, 6'h00, 1'b0);
        addRow(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b1, 3'd2, 5'b00000, 1'b1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        addRow(1'b0, 6'h2B, 6'h00, 1'b0, 1'b1, 1'b1, 3'd3, 5'b00001, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);

        rowIF(6'h08, 6'h00, 1'b0);
        rowID(6'h08, 6'h00, 1'b0);
        addRow(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, 1'b1, 3'd2, 5'b00000, 1'b1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        addRow(1'b0, 6'h08, 6'h00, 1'b0, 1'b1, 1'b1, 3'd4, 5'b00100, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);

        rowIF(6'h0E, 6'h00, 1'b0);
        rowID(6'h0E, 6'h00, 1'b0);
        addRow(1'b0, 6'h0E, 6'h00, 1'b0, 1'b1, 1'b1, 3'd2, 5'b00000, 1'b1, 2'd3, 2'd3, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        addRow(1'b0, 6'h0E, 6'h00, 1'b0, 1'b1, 1'b1, 3'd4, 5'b00100, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);

        rowIF(6'h00, 6'h2A, 1'b0);
        rowID(6'h00, 6'h2A, 1'b0);
        addRow(1'b0, 6'h00, 6'h2A, 1'b0, 1'b1, 1'b1, 3'd2, 5'b00000, 1'b1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        addRow(1'b0, 6'h00, 6'h2A, 1'b0, 1'b1, 1'b1, 3'd4, 5'b00100, 1'b0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0);

        rowIF(6'h3F, 6'h00, 1'b0);
        idxIllId = vecs.size();
        rowID(6'h3F, 6'h00, 1'b0);
        for (int k = 0; k < 10; k++) begin
            addRow(1'b0, 6'h3F, 6'h00, 1'b0, 1'b1, 1'b1, 3'd7, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
        end

        addRow(1'b1, 6'h00, 6'h22, 1'b0, 1'b1, 1'b1, 3'd7, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b1);
        rowIF(6'h00, 6'h22, 1'b0);
        rowID(6'h00, 6'h22, 1'b0);
        addRow(1'b1, 6'h00, 6'h22, 1'b0, 1'b1, 1'b1, 3'd2, 5'b00000, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) begin
            addRow(1'b0, 6'h00, 6'h22, 1'b0, 1'b0, 1'b1, 3'd0, 5'b00000, 1'b0, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0);
        end
        rowIF(6'h00, 6'h22, 1'b0);
        rowID(6'h00, 6'h22, 1'b0);
    endfunction

    // Drive one cycle of inputs half a period ahead of the edge that uses
    // them, queue the expected outputs, and let the combinational outputs
    // settle before they are looked at.
    task automatic applyStimulus(input step_t s);
        @(negedge clk);
        reset      = s.rst;
        opcode     = s.op;
        funct      = s.fn;
        zero       = s.z;
        imem_ready = s.ir;
        dmem_ready = s.dr;
        expQ.push_back(s);
        #1;
    endtask

    // Pop the oldest expectation and compare the whole control word, the
    // flags and the counter at once; then advance the expected counter by
    // what the coming edge should do to it.
    task automatic checkOutput(input int idx);
        step_t       e;
        logic [52:0] got;
        logic [52:0] want;
        e    = expQ.pop_front();
        got  = {state, pc_we, ir_we, reg_we, mem_re, mem_we, alu_src_a, alu_src_b,
                alu_op, reg_dst, mem_to_reg, pc_src, retire, illegal, instret};
        want = {e.st, e.en, e.a, e.b, e.aop, e.dst, e.m2r, e.psrc, e.ret, e.ill, expInstret};
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL row%0d ctrl got=%h want=%h", idx, got, want);
        end
        if (e.rst) begin
            expInstret = '0;
        end else if (e.ret) begin
            expInstret = expInstret + 32'd1;
        end
    endtask

    task automatic compareVal(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // The non-trapping instance retires the undefined instruction from ID
    // and is back in IF one cycle later with its counter one ahead.
    task automatic checkNoTrap(input int idx);
        if (idx == idxIllId) begin
            compareVal("notrap_id", {stateN, retireN, illegalN, pcWeN, regWeN},
                       {3'd1, 1'b1, 1'b0, 1'b0, 1'b0});
        end else if (idx == idxIllId + 1) begin
            compareVal("notrap_if_state", {stateN, illegalN}, {3'd0, 1'b0});
            compareVal("notrap_instret", instretN, expInstret + 32'd1);
        end
    endtask

    initial begin
        reset      = 1'b1;
        opcode     = '0;
        funct      = '0;
        zero       = 1'b0;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        fillTable();
        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkNoTrap(i);
            checkOutput(i);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
